// File: rtl/mult_input_pkg.sv
// Shared types and key polarity constants for the multiplier input conditioner.
package mult_input_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } deb_state_t;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// One active-low key: synchronizer chain, four-state debounce FSM with a stability
// counter, and registered level and press-pulse outputs. inhibit holds off acceptance.
module key_debounce
  import mult_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_n,
  input  logic inhibit,
  output logic level,
  output logic pulse
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  deb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks execute in.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) sync_q <= {SYNC_STAGES{KEY_RELEASED}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RELEASED: begin
        if (synced == KEY_PRESSED) begin
          state_d = PRESS_PEND;
          cnt_d   = '0;
        end
      end
      PRESS_PEND: begin
        if (synced == KEY_RELEASED) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          // Saturate at the last count while inhibited; accept once released.
          if (!inhibit) state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (synced == KEY_RELEASED) begin
          state_d = RELEASE_PEND;
          cnt_d   = '0;
        end
      end
      RELEASE_PEND: begin
        if (synced == KEY_PRESSED) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as the FSM.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level   <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= (state_d == PRESSED) || (state_d == RELEASE_PEND);
      pulse   <= (state_q == PRESS_PEND) && (state_d == PRESSED);
    end
  end

endmodule

// File: rtl/mult_input_conditioner.sv
// Multiplier front end: debounced Run / ClearA_LoadB keys, synchronized switches and
// the operand word captured on a load press. Define MULT_KEY_LOCKOUT_EN to block loads while Run is held.
module mult_input_conditioner
  import mult_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2,
  parameter int SW_WIDTH        = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run_n,
  input  logic                ClearA_LoadB_n,
  input  logic [SW_WIDTH-1:0] SW,
  output logic                Run,
  output logic                ClearA_LoadB,
  output logic                Run_pulse,
  output logic                Load_pulse,
  output logic [SW_WIDTH-1:0] SW_sync,
  output logic [SW_WIDTH-1:0] SW_held
);

  logic [SW_WIDTH-1:0] sw_sync_q [SYNC_STAGES];
  logic                load_inhibit;

  // NOTE: this array is a flop chain, not a RAM, so every stage is reset; a
  // true memory would be left unreset and initialised by its users instead.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
    end else begin
      sw_sync_q[0] <= SW;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
    end
  end

  assign SW_sync = sw_sync_q[SYNC_STAGES-1];

`ifdef MULT_KEY_LOCKOUT_EN
  assign load_inhibit = Run;
`else
  assign load_inhibit = 1'b0;
`endif

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_run_key (
    .Clk     (Clk),
    .Reset   (Reset),
    .key_n   (Run_n),
    .inhibit (1'b0),
    .level   (Run),
    .pulse   (Run_pulse)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_load_key (
    .Clk     (Clk),
    .Reset   (Reset),
    .key_n   (ClearA_LoadB_n),
    .inhibit (load_inhibit),
    .level   (ClearA_LoadB),
    .pulse   (Load_pulse)
  );

  // Capture the switch word present during the load strobe cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)           SW_held <= '0;
    else if (Load_pulse) SW_held <= SW_sync;
  end

endmodule
